cache_replacement_controller: RTL and testbench
===============================================

Name: cache_replacement_controller

Overview:
Per-request sequencer for one set-associative cache. It accepts one lookup at a time and consumes hit/victim info from the tag array. It drives the lru_counters update strobe with the correct set/way, and sequences dirty-victim writeback and line fill over a simple memory request/response channel. It sits between the core-side request port, the tag/LRU arrays and the memory interface.

Parameters:
NUM_SETS, 1, number of sets; SET_SIZE = $clog2(NUM_SETS)
ASSOC, 2, ways per set; ASSOC_SIZE = $clog2(ASSOC); must be >1 and even (elaboration $error otherwise)
TAG_WIDTH, 20, tag bits carried to memory address

Ports:
clk  input  1  single clock, all logic posedge
reset  input  1  synchronous, active-high
req_valid  input  1  core request present
req_ready  output  1  controller can accept (IDLE only)
req_set  input  SET_SIZE  request set index
req_tag  input  TAG_WIDTH  request tag
lookup_set  output  SET_SIZE  latched set to tag array and lru_counters
tag_hit  input  1  tag array hit for lookup_set/latched tag (combinational, valid in LOOKUP)
hit_way  input  ASSOC_SIZE  hitting way
victim_way  input  ASSOC_SIZE  from lru_counters
victim_valid  input  1  victim line valid
victim_dirty  input  1  victim line dirty
victim_tag  input  TAG_WIDTH  victim line tag
process_lru_counters  output  1  one-cycle LRU update strobe
lru_selected_way  output  ASSOC_SIZE  way to promote to MRU
mem_req_valid  output  1  memory request
mem_req_ready  input  1  memory accepts request
mem_req_write  output  1  1=writeback, 0=fill read
mem_req_tag  output  TAG_WIDTH  victim_tag for writeback, latched req tag for fill
mem_resp_valid  input  1  memory completion pulse
fill_en  output  1  one-cycle write of fill data into fill_way
fill_way  output  ASSOC_SIZE  latched victim way
resp_valid  output  1  one-cycle completion pulse to core
resp_hit  output  1  1 if request hit (valid with resp_valid)

Behaviour:
- States: IDLE, LOOKUP, WB_REQ, WB_WAIT, FILL_REQ, FILL_WAIT, UPDATE, RESPOND.
- Reset value: state IDLE. All outputs 0, except req_ready=1 in the first cycle after reset deasserts. Latched set/tag/way cleared to 0.
- IDLE: req_ready=1. On req_valid, latch req_set/req_tag and go to LOOKUP.
- LOOKUP (1 cycle): on tag_hit, latch way=hit_way, hit=1, go to UPDATE. On miss, latch way=victim_way and victim_tag, hit=0. Go to WB_REQ if victim_valid&victim_dirty, else FILL_REQ.
- WB_REQ: mem_req_valid=1, write=1, tag=latched victim_tag. Hold until mem_req_ready, then go to WB_WAIT.
- WB_WAIT: on mem_resp_valid go to FILL_REQ.
- FILL_REQ: mem_req_valid=1, write=0, tag=latched req tag. Hold until mem_req_ready, then go to FILL_WAIT.
- FILL_WAIT: on mem_resp_valid, pulse fill_en with fill_way=latched way in the same cycle, then go to UPDATE.
- UPDATE: process_lru_counters=1 for exactly one cycle, with lookup_set and lru_selected_way=latched way. Then go to RESPOND.
- RESPOND: resp_valid=1 and resp_hit=latched hit for one cycle. Then go to IDLE.
- Latency from accept to resp_valid: hit = 3 cycles; clean miss = 5 + memory wait cycles.
- Victim way is latched in LOOKUP. Later LRU activity cannot change the replaced way.
- lookup_set is stable from LOOKUP through RESPOND.
- mem_req_valid, once raised, stays high with stable write/tag until mem_req_ready.
- mem_resp_valid outside WB_WAIT/FILL_WAIT is ignored.
- Reset in any state: next cycle is IDLE and all outputs are 0. In-flight memory transactions are abandoned; the memory model must tolerate this.
- Never more than one process_lru_counters pulse per accepted request.

Optional Feature:
CACHE_PERF_COUNTERS_EN
- Defined: adds outputs hit_count and miss_count (32 bits each) and writeback_count (32 bits), all zeroed by reset.
  - hit_count / miss_count increment in RESPOND on resp_hit=1 / resp_hit=0.
  - writeback_count increments on WB_REQ handshake.
  - All saturate at all-ones.
- Undefined: these ports and registers do not exist; behaviour otherwise identical.

Decomposition:
- Package cache_ctrl_pkg holds:
  - typedef enum logic [2:0] cache_ctrl_state_t (the eight states)
  - constant PERF_CNT_WIDTH = 32
- Sub-module cache_perf_counters contains the three saturating counters and is instantiated only under CACHE_PERF_COUNTERS_EN.
- The FSM stays in one module.

Test Plan:
- Hit: NUM_SETS=4, ASSOC=4; req set=2 hits way 1 -> process_lru_counters pulses at cycle 2 with set=2, way=1; resp_valid=1, resp_hit=1 at cycle 3; no mem_req_valid.
- Clean miss: victim_way=3, victim_valid=0 -> FILL_REQ read with mem_req_tag=req tag; mem_resp_valid gives fill_en with fill_way=3; then LRU pulse with way=3; resp_hit=0.
- Dirty miss with backpressure: victim_dirty=1, victim_tag=0xABC, mem_req_ready low for 3 cycles -> write request held stable 4 cycles; then the fill read; exactly one fill_en and one LRU pulse.
- Victim changes mid-miss: victim_way driven 2 in LOOKUP then 0 afterwards -> fill_way and lru_selected_way both 2.
- Reset in FILL_WAIT -> next cycle IDLE, req_ready=1, all strobes 0. A stray mem_resp_valid then is ignored.
- CACHE_PERF_COUNTERS_EN: 3 hits, 2 misses (1 dirty) -> hit_count=3, miss_count=2, writeback_count=1.

Source files
------------

// File: rtl/cache_ctrl_pkg.sv
// Shared types and constants for the cache replacement controller.
package cache_ctrl_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_LOOKUP,
        ST_WB_REQ,
        ST_WB_WAIT,
        ST_FILL_REQ,
        ST_FILL_WAIT,
        ST_UPDATE,
        ST_RESPOND
    } cache_ctrl_state_t;

    localparam int unsigned PERF_CNT_WIDTH = 32;

endpackage

// File: rtl/cache_perf_counters.sv
// Saturating hit/miss/writeback event counters for the cache replacement controller.
module cache_perf_counters
    import cache_ctrl_pkg::*;
(
    input  logic                      clk,
    input  logic                      reset,
    input  logic                      hit_inc,
    input  logic                      miss_inc,
    input  logic                      wb_inc,
    output logic [PERF_CNT_WIDTH-1:0] hit_count,
    output logic [PERF_CNT_WIDTH-1:0] miss_count,
    output logic [PERF_CNT_WIDTH-1:0] writeback_count
);

    always_ff @(posedge clk) begin
        if (reset) begin
            hit_count       <= '0;
            miss_count      <= '0;
            writeback_count <= '0;
        end else begin
            if (hit_inc && hit_count != '1)
                hit_count <= hit_count + PERF_CNT_WIDTH'(1);
            if (miss_inc && miss_count != '1)
                miss_count <= miss_count + PERF_CNT_WIDTH'(1);
            if (wb_inc && writeback_count != '1)
                writeback_count <= writeback_count + PERF_CNT_WIDTH'(1);
        end
    end

endmodule

// File: rtl/cache_replacement_controller.sv
// Per-request lookup / writeback / fill / LRU-update sequencer for one set-associative cache.
// Optional performance counters are built when CACHE_PERF_COUNTERS_EN is defined.
module cache_replacement_controller
    import cache_ctrl_pkg::*;
#(
    parameter  int NUM_SETS   = 1,
    parameter  int ASSOC      = 2,
    parameter  int TAG_WIDTH  = 20,
    localparam int SET_SIZE   = (NUM_SETS > 1) ? $clog2(NUM_SETS) : 1,
    localparam int ASSOC_SIZE = $clog2(ASSOC)
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  req_valid,
    output logic                  req_ready,
    input  logic [SET_SIZE-1:0]   req_set,
    input  logic [TAG_WIDTH-1:0]  req_tag,
    output logic [SET_SIZE-1:0]   lookup_set,
    input  logic                  tag_hit,
    input  logic [ASSOC_SIZE-1:0] hit_way,
    input  logic [ASSOC_SIZE-1:0] victim_way,
    input  logic                  victim_valid,
    input  logic                  victim_dirty,
    input  logic [TAG_WIDTH-1:0]  victim_tag,
    output logic                  process_lru_counters,
    output logic [ASSOC_SIZE-1:0] lru_selected_way,
    output logic                  mem_req_valid,
    input  logic                  mem_req_ready,
    output logic                  mem_req_write,
    output logic [TAG_WIDTH-1:0]  mem_req_tag,
    input  logic                  mem_resp_valid,
    output logic                  fill_en,
    output logic [ASSOC_SIZE-1:0] fill_way,
    output logic                  resp_valid,
    output logic                  resp_hit
`ifdef CACHE_PERF_COUNTERS_EN
    ,
    output logic [PERF_CNT_WIDTH-1:0] hit_count,
    output logic [PERF_CNT_WIDTH-1:0] miss_count,
    output logic [PERF_CNT_WIDTH-1:0] writeback_count
`endif
);

    if (ASSOC < 2 || (ASSOC % 2) != 0) begin : g_assoc_check
        $error("cache_replacement_controller: ASSOC must be >1 and even");
    end

    cache_ctrl_state_t     state, state_nxt;
    logic [SET_SIZE-1:0]   set_q;
    logic [TAG_WIDTH-1:0]  tag_q;
    logic [TAG_WIDTH-1:0]  vtag_q;
    logic [ASSOC_SIZE-1:0] way_q;
    logic                  hit_q;

    // Way and victim tag are captured once in LOOKUP so later LRU churn cannot redirect the fill.
    always_ff @(posedge clk) begin
        if (reset) begin
            state  <= ST_IDLE;
            set_q  <= '0;
            tag_q  <= '0;
            vtag_q <= '0;
            way_q  <= '0;
            hit_q  <= 1'b0;
        end else begin
            state <= state_nxt;
            case (state)
                ST_IDLE: begin
                    if (req_valid) begin
                        set_q <= req_set;
                        tag_q <= req_tag;
                    end
                end
                ST_LOOKUP: begin
                    if (tag_hit) begin
                        way_q <= hit_way;
                        hit_q <= 1'b1;
                    end else begin
                        way_q  <= victim_way;
                        vtag_q <= victim_tag;
                        hit_q  <= 1'b0;
                    end
                end
                default: ;
            endcase
        end
    end

    always_comb begin
        state_nxt            = state;
        req_ready            = 1'b0;
        process_lru_counters = 1'b0;
        mem_req_valid        = 1'b0;
        mem_req_write        = 1'b0;
        mem_req_tag          = '0;
        fill_en              = 1'b0;
        resp_valid           = 1'b0;
        resp_hit             = 1'b0;
        case (state)
            ST_IDLE: begin
                req_ready = !reset;
                if (req_valid)
                    state_nxt = ST_LOOKUP;
            end
            ST_LOOKUP: begin
                if (tag_hit)
                    state_nxt = ST_UPDATE;
                else if (victim_valid && victim_dirty)
                    state_nxt = ST_WB_REQ;
                else
                    state_nxt = ST_FILL_REQ;
            end
            ST_WB_REQ: begin
                mem_req_valid = 1'b1;
                mem_req_write = 1'b1;
                mem_req_tag   = vtag_q;
                if (mem_req_ready)
                    state_nxt = ST_WB_WAIT;
            end
            ST_WB_WAIT: begin
                if (mem_resp_valid)
                    state_nxt = ST_FILL_REQ;
            end
            ST_FILL_REQ: begin
                mem_req_valid = 1'b1;
                mem_req_tag   = tag_q;
                if (mem_req_ready)
                    state_nxt = ST_FILL_WAIT;
            end
            ST_FILL_WAIT: begin
                if (mem_resp_valid) begin
                    fill_en   = 1'b1;
                    state_nxt = ST_UPDATE;
                end
            end
            ST_UPDATE: begin
                process_lru_counters = 1'b1;
                state_nxt            = ST_RESPOND;
            end
            ST_RESPOND: begin
                resp_valid = 1'b1;
                resp_hit   = hit_q;
                state_nxt  = ST_IDLE;
            end
            default: state_nxt = ST_IDLE;
        endcase
    end

    assign lookup_set       = set_q;
    assign lru_selected_way = way_q;
    assign fill_way         = way_q;

`ifdef CACHE_PERF_COUNTERS_EN
    cache_perf_counters u_perf (
        .clk             (clk),
        .reset           (reset),
        .hit_inc         (state == ST_RESPOND && hit_q),
        .miss_inc        (state == ST_RESPOND && !hit_q),
        .wb_inc          (state == ST_WB_REQ && mem_req_ready),
        .hit_count       (hit_count),
        .miss_count      (miss_count),
        .writeback_count (writeback_count)
    );
`endif

endmodule

// File: tb/tb_cache_replacement_controller.sv
// Self-checking bench for cache_replacement_controller (NUM_SETS=4, ASSOC=4) with a response scoreboard.
module tb_cache_replacement_controller;

    logic        clk = 1'b0;
    logic        reset;
    logic        req_valid;
    logic        req_ready;
    logic [1:0]  req_set;
    logic [19:0] req_tag;
    logic [1:0]  lookup_set;
    logic        tag_hit;
    logic [1:0]  hit_way;
    logic [1:0]  victim_way;
    logic        victim_valid;
    logic        victim_dirty;
    logic [19:0] victim_tag;
    logic        process_lru_counters;
    logic [1:0]  lru_selected_way;
    logic        mem_req_valid;
    logic        mem_req_ready;
    logic        mem_req_write;
    logic [19:0] mem_req_tag;
    logic        mem_resp_valid;
    logic        fill_en;
    logic [1:0]  fill_way;
    logic        resp_valid;
    logic        resp_hit;
`ifdef CACHE_PERF_COUNTERS_EN
    logic [31:0] hit_count, miss_count, writeback_count;
`endif

    typedef struct {
        logic hit;
        int   lat;
    } exp_t;
    exp_t sb[$];

    int n_tests = 0;
    int n_fail  = 0;

    always #5 clk = ~clk;

    cache_replacement_controller #(.NUM_SETS(4), .ASSOC(4), .TAG_WIDTH(20)) dut (
        .clk(clk), .reset(reset),
        .req_valid(req_valid), .req_ready(req_ready), .req_set(req_set), .req_tag(req_tag),
        .lookup_set(lookup_set), .tag_hit(tag_hit), .hit_way(hit_way),
        .victim_way(victim_way), .victim_valid(victim_valid), .victim_dirty(victim_dirty),
        .victim_tag(victim_tag), .process_lru_counters(process_lru_counters),
        .lru_selected_way(lru_selected_way), .mem_req_valid(mem_req_valid),
        .mem_req_ready(mem_req_ready), .mem_req_write(mem_req_write), .mem_req_tag(mem_req_tag),
        .mem_resp_valid(mem_resp_valid), .fill_en(fill_en), .fill_way(fill_way),
        .resp_valid(resp_valid), .resp_hit(resp_hit)
`ifdef CACHE_PERF_COUNTERS_EN
        , .hit_count(hit_count), .miss_count(miss_count), .writeback_count(writeback_count)
`endif
    );

    // One full request: drives the core/tag side, plays the memory, checks every cycle up to RESPOND.
    task automatic run_req(input string name, input logic [1:0] set, input logic [19:0] tag,
                           input logic hit, input logic [1:0] hway, input logic [1:0] vway,
                           input logic [1:0] vway_late, input logic vvalid, input logic vdirty,
                           input logic [19:0] vtag, input int rd, input int rsp);
        exp_t        e;
        logic [1:0]  exp_way;
        logic        dirty, exp_w, wb_done, pend, done;
        int          wb_cycles, rd_cycles, fills, lrus, held, wait_cnt;
        exp_way   = hit ? hway : vway;
        dirty     = !hit && vvalid && vdirty;
        wb_done   = 1'b0;
        pend      = 1'b0;
        done      = 1'b0;
        wb_cycles = 0; rd_cycles = 0; fills = 0; lrus = 0; held = 0; wait_cnt = 0;

        @(posedge clk); #2;
        n_tests++;
        if (req_ready !== 1'b1) begin
            n_fail++; $display("FAIL %s.req_ready: got %b expected 1", name, req_ready);
        end
        req_valid = 1'b1; req_set = set; req_tag = tag;
        tag_hit = hit; hit_way = hway; victim_way = vway;
        victim_valid = vvalid; victim_dirty = vdirty; victim_tag = vtag;
        e.hit = hit;
        e.lat = hit ? 3 : (5 + rd + rsp + (dirty ? 2 + rd + rsp : 0));
        sb.push_back(e);

        for (int cyc = 1; cyc <= 200 && !done; cyc++) begin
            @(posedge clk); #1;
            req_valid = 1'b0;
            if (cyc == 2) begin
                victim_way = vway_late; tag_hit = 1'b0; hit_way = ~hway; victim_tag = ~vtag;
            end
            mem_resp_valid = 1'b0;
            if (pend) begin
                wait_cnt++;
                if (wait_cnt > rsp) begin
                    mem_resp_valid = 1'b1; pend = 1'b0;
                end
            end
            exp_w = dirty && !wb_done;
            if (mem_req_valid) begin
                held++;
                if (mem_req_write) wb_cycles++; else rd_cycles++;
                n_tests++;
                if (mem_req_write !== exp_w || mem_req_tag !== (exp_w ? vtag : tag)) begin
                    n_fail++;
                    $display("FAIL %s.mem_req cyc%0d: got write=%b tag=%h expected write=%b tag=%h",
                             name, cyc, mem_req_write, mem_req_tag, exp_w, exp_w ? vtag : tag);
                end
                mem_req_ready = (held > rd);
                if (mem_req_ready) begin
                    pend = 1'b1; wait_cnt = 0; held = 0;
                    if (exp_w) wb_done = 1'b1;
                end
            end else begin
                mem_req_ready = 1'b0;
            end
            #1;
            n_tests++;
            if (lookup_set !== set) begin
                n_fail++; $display("FAIL %s.lookup_set cyc%0d: got %0d expected %0d", name, cyc, lookup_set, set);
            end
            if (fill_en) begin
                fills++;
                n_tests++;
                if (fill_way !== exp_way || mem_resp_valid !== 1'b1) begin
                    n_fail++; $display("FAIL %s.fill: got way=%0d resp=%b expected way=%0d resp=1",
                                       name, fill_way, mem_resp_valid, exp_way);
                end
            end
            if (process_lru_counters) begin
                lrus++;
                n_tests++;
                if (lru_selected_way !== exp_way || lookup_set !== set) begin
                    n_fail++; $display("FAIL %s.lru: got set=%0d way=%0d expected set=%0d way=%0d",
                                       name, lookup_set, lru_selected_way, set, exp_way);
                end
            end
            if (resp_valid) begin
                done = 1'b1;
                n_tests++;
                if (sb.size() == 0) begin
                    n_fail++; $display("FAIL %s.resp: got unexpected response expected none", name);
                end else begin
                    e = sb.pop_front();
                    if (resp_hit !== e.hit || cyc != e.lat) begin
                        n_fail++; $display("FAIL %s.resp: got hit=%b lat=%0d expected hit=%b lat=%0d",
                                           name, resp_hit, cyc, e.hit, e.lat);
                    end
                end
            end
        end
        mem_resp_valid = 1'b0; mem_req_ready = 1'b0;
        n_tests++;
        if (!done) begin
            n_fail++; $display("FAIL %s.timeout: got no response expected one within 200 cycles", name);
        end
        n_tests++;
        if (lrus != 1 || fills != (hit ? 0 : 1)) begin
            n_fail++; $display("FAIL %s.pulses: got lru=%0d fill=%0d expected lru=1 fill=%0d",
                               name, lrus, fills, hit ? 0 : 1);
        end
        n_tests++;
        if (wb_cycles != (dirty ? rd + 1 : 0) || rd_cycles != (hit ? 0 : rd + 1)) begin
            n_fail++; $display("FAIL %s.mem_cycles: got wb=%0d rd=%0d expected wb=%0d rd=%0d",
                               name, wb_cycles, rd_cycles, dirty ? rd + 1 : 0, hit ? 0 : rd + 1);
        end
    endtask

    task automatic test_reset();
        reset = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        n_tests++;
        if ({req_ready, process_lru_counters, mem_req_valid, fill_en, resp_valid, resp_hit} !== 6'b0 ||
            {lookup_set, lru_selected_way, fill_way, mem_req_tag} !== 26'b0) begin
            n_fail++; $display("FAIL reset.outputs: got ready=%b lru=%b mreq=%b fill=%b resp=%b set=%0d expected all 0",
                               req_ready, process_lru_counters, mem_req_valid, fill_en, resp_valid, lookup_set);
        end
        reset = 1'b0;
        #1;
        n_tests++;
        if (req_ready !== 1'b1) begin
            n_fail++; $display("FAIL reset.req_ready_after: got %b expected 1", req_ready);
        end
    endtask

    task automatic test_hit();
        run_req("hit", 2'd2, 20'h12345, 1'b1, 2'd1, 2'd3, 2'd3, 1'b1, 1'b1, 20'h55555, 0, 0);
    endtask

    task automatic test_clean_miss();
        run_req("clean_miss", 2'd1, 20'h0F00D, 1'b0, 2'd0, 2'd3, 2'd3, 1'b0, 1'b1, 20'h11111, 0, 2);
    endtask

    task automatic test_dirty_miss_backpressure();
        run_req("dirty_miss", 2'd3, 20'h00777, 1'b0, 2'd0, 2'd1, 2'd1, 1'b1, 1'b1, 20'h00ABC, 3, 1);
    endtask

    task automatic test_victim_change();
        run_req("victim_change", 2'd0, 20'hBEEF0, 1'b0, 2'd1, 2'd2, 2'd0, 1'b1, 1'b0, 20'h22222, 0, 0);
    endtask

    task automatic test_back_to_back();
        for (int i = 0; i < 6; i++) begin
            run_req("b2b", 2'($urandom_range(0, 3)), 20'($urandom), 1'($urandom_range(0, 1)),
                    2'($urandom_range(0, 3)), 2'($urandom_range(0, 3)), 2'($urandom_range(0, 3)),
                    1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 20'($urandom),
                    $urandom_range(0, 2), $urandom_range(0, 3));
        end
    endtask

    task automatic test_reset_in_fill_wait();
        @(posedge clk); #2;
        req_valid = 1'b1; req_set = 2'd1; req_tag = 20'hCAFE0;
        tag_hit = 1'b0; victim_way = 2'd1; victim_valid = 1'b0; victim_dirty = 1'b0;
        @(posedge clk); #1;                     // LOOKUP
        req_valid = 1'b0;
        @(posedge clk); #1;                     // FILL_REQ
        n_tests++;
        if (mem_req_valid !== 1'b1 || mem_req_write !== 1'b0) begin
            n_fail++; $display("FAIL rst_fw.fill_req: got valid=%b write=%b expected valid=1 write=0",
                               mem_req_valid, mem_req_write);
        end
        mem_req_ready = 1'b1;
        @(posedge clk); #1;                     // FILL_WAIT
        mem_req_ready = 1'b0;
        reset = 1'b1;
        @(posedge clk); #1;
        reset = 1'b0;
        #1;
        n_tests++;
        if (req_ready !== 1'b1 || {process_lru_counters, mem_req_valid, fill_en, resp_valid} !== 4'b0 ||
            {lookup_set, fill_way} !== 4'b0) begin
            n_fail++; $display("FAIL rst_fw.idle: got ready=%b lru=%b mreq=%b fill=%b resp=%b set=%0d way=%0d expected ready=1 rest 0",
                               req_ready, process_lru_counters, mem_req_valid, fill_en, resp_valid, lookup_set, fill_way);
        end
        mem_resp_valid = 1'b1;
        #1;
        n_tests++;
        if (fill_en !== 1'b0) begin
            n_fail++; $display("FAIL rst_fw.stray_fill: got %b expected 0", fill_en);
        end
        for (int i = 0; i < 3; i++) begin
            @(posedge clk); #1;
            mem_resp_valid = 1'b0;
            #1;
            n_tests++;
            if (req_ready !== 1'b1 || {process_lru_counters, fill_en, resp_valid, mem_req_valid} !== 4'b0) begin
                n_fail++; $display("FAIL rst_fw.stray_ignored: got ready=%b lru=%b fill=%b resp=%b mreq=%b expected ready=1 rest 0",
                                   req_ready, process_lru_counters, fill_en, resp_valid, mem_req_valid);
            end
        end
    endtask

`ifdef CACHE_PERF_COUNTERS_EN
    task automatic test_perf_counters();
        @(posedge clk); #1;
        reset = 1'b1;
        @(posedge clk); #1;
        reset = 1'b0;
        for (int i = 0; i < 3; i++)
            run_req("perf_hit", 2'(i), 20'h100 + 20'(i), 1'b1, 2'(i), 2'd0, 2'd0, 1'b1, 1'b1, 20'h3, 0, 0);
        run_req("perf_dirty", 2'd1, 20'h200, 1'b0, 2'd0, 2'd2, 2'd2, 1'b1, 1'b1, 20'h201, 1, 0);
        run_req("perf_clean", 2'd2, 20'h300, 1'b0, 2'd0, 2'd3, 2'd3, 1'b1, 1'b0, 20'h301, 0, 1);
        @(posedge clk); #2;
        n_tests++;
        if (hit_count !== 32'd3 || miss_count !== 32'd2 || writeback_count !== 32'd1) begin
            n_fail++; $display("FAIL perf.counts: got hit=%0d miss=%0d wb=%0d expected 3 2 1",
                               hit_count, miss_count, writeback_count);
        end
    endtask
`endif

    initial begin
        reset = 1'b1; req_valid = 1'b0; req_set = '0; req_tag = '0;
        tag_hit = 1'b0; hit_way = '0; victim_way = '0; victim_valid = 1'b0;
        victim_dirty = 1'b0; victim_tag = '0; mem_req_ready = 1'b0; mem_resp_valid = 1'b0;
        test_reset();
        test_hit();
        test_clean_miss();
        test_dirty_miss_backpressure();
        test_victim_change();
        test_back_to_back();
        test_reset_in_fill_wait();
`ifdef CACHE_PERF_COUNTERS_EN
        test_perf_counters();
`endif
        n_tests++;
        if (sb.size() != 0) begin
            n_fail++; $display("FAIL scoreboard.leftover: got %0d entries expected 0", sb.size());
        end
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
